// File: rtl/qsort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qsort_pkg
// Description : Shared types and default sizes for the quicksort sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package qsort_pkg;

    localparam int c_IDX_W       = 32;
    localparam int c_STACK_DEPTH = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_PUSH_R = 3'd3,
        S_PUSH_L = 3'd4,
        S_POP    = 3'd5,
        S_FINISH = 3'd6
    } qseq_state_t;

    typedef struct packed {
        logic [c_IDX_W-1:0] lo;
        logic [c_IDX_W-1:0] hi;
    } interval_t;

endpackage
`default_nettype wire

// File: rtl/qsort_sequencer_stack.sv
`default_nettype none
// ============================================================================
// Module      : interval_stack
// Description : LIFO of index intervals with a registered pop output.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_stack
    import qsort_pkg::*;
#(
    parameter int  DEPTH   = c_STACK_DEPTH,
    parameter type ENTRY_T = interval_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_push,
    input  logic   i_pop,
    input  ENTRY_T i_data,
    output ENTRY_T o_data,
    output logic   o_full,
    output logic   o_empty
);

    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ENTRY_T             r_mem [DEPTH];
    ENTRY_T             r_data;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_top;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_top     = r_count - c_CNT_W'(1);
    assign o_data    = r_data;

    // Storage carries no reset; emptiness is defined by the counter alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_count[c_ADDR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_data  <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + c_CNT_W'(1);
        end else if (w_do_pop) begin
            r_count <= w_top;
            r_data  <= r_mem[w_top[c_ADDR_W-1:0]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/qsort_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qsort_sequencer
// Description : Drives a partition engine through an in-place quicksort.
// Revision    : 1.0 - initial release
// ============================================================================
module qsort_sequencer
    import qsort_pkg::*;
#(
    parameter int IDX_W       = c_IDX_W,
    parameter int STACK_DEPTH = c_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] size,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             err,
    output logic             part_start,
    output logic [IDX_W-1:0] part_lo,
    output logic [IDX_W-1:0] part_hi,
    input  logic             part_done,
    input  logic [IDX_W-1:0] part_pivot
);

    typedef struct packed {
        logic [IDX_W-1:0] lo;
        logic [IDX_W-1:0] hi;
    } ival_t;

    qseq_state_t      r_state;
    qseq_state_t      w_next;
    ival_t            r_cur;
    ival_t            w_issue_ival;
    ival_t            w_push_data;
    ival_t            w_pop_data;
    logic [IDX_W-1:0] r_pivot;
    logic             r_from_pop;
    logic             r_overflow;
    logic             r_err;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_pivot_bad;
    logic             w_right_ok;
    logic             w_left_ok;
    logic             w_accept_sort;

    assign w_accept_sort = start && (size >= IDX_W'(2));
    assign w_pivot_bad   = (part_pivot < r_cur.lo) || (part_pivot > r_cur.hi);
    // The first term of each guard rules out wrap in the second.
    assign w_right_ok    = (r_pivot < r_cur.hi) && ((r_pivot + IDX_W'(1)) < r_cur.hi);
    assign w_left_ok     = (r_pivot > r_cur.lo) && ((r_pivot - IDX_W'(1)) > r_cur.lo);

    // Popped data lands one cycle after POP, so ISSUE forwards it directly.
    assign w_issue_ival  = ((r_state == S_ISSUE) && r_from_pop) ? w_pop_data : r_cur;

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign part_start = (r_state == S_ISSUE);
    assign part_lo    = w_issue_ival.lo;
    assign part_hi    = w_issue_ival.hi;
    assign overflow   = r_overflow;
    assign err        = r_err;

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_data = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_accept_sort ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (part_done) begin
                    w_next = w_pivot_bad ? S_POP : S_PUSH_R;
                end
            end
            S_PUSH_R: begin
                w_push         = w_right_ok;
                w_push_data.lo = r_pivot + IDX_W'(1);
                w_push_data.hi = r_cur.hi;
                w_next         = S_PUSH_L;
            end
            S_PUSH_L: begin
                w_push         = w_left_ok;
                w_push_data.lo = r_cur.lo;
                w_push_data.hi = r_pivot - IDX_W'(1);
                w_next         = S_POP;
            end
            S_POP: begin
                if (w_empty) begin
                    w_next = S_FINISH;
                end else begin
                    w_pop  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_pivot    <= '0;
            r_from_pop <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_from_pop <= (r_state == S_POP);
            case (r_state)
                S_IDLE: begin
                    if (w_accept_sort) begin
                        r_cur.lo   <= '0;
                        r_cur.hi   <= size - IDX_W'(1);
                        r_overflow <= 1'b0;
                        r_err      <= 1'b0;
                    end
                end
                S_ISSUE: r_cur <= w_issue_ival;
                S_WAIT: begin
                    if (part_done) begin
                        r_pivot <= part_pivot;
                        if (w_pivot_bad) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_PUSH_R, S_PUSH_L: begin
                    if (w_push && w_full) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    interval_stack #(
        .DEPTH   (STACK_DEPTH),
        .ENTRY_T (ival_t)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_pop_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire
